// File: rtl/movimentacao_pkg.sv
// Shared types and constants for the vacuum robot movement controller.
// State codes, wheel command codes and the per-state motor decode.
package movimentacao_pkg;

  typedef enum logic [2:0] {
    PARADO   = 3'd0,
    FRENTE   = 3'd1,
    RE       = 3'd2,
    GIRO_ESQ = 3'd3,
    GIRO_DIR = 3'd4,
    PRESO    = 3'd5
  } estado_t;

  localparam logic [1:0] MOTOR_PARA   = 2'b00;
  localparam logic [1:0] MOTOR_FRENTE = 2'b01;
  localparam logic [1:0] MOTOR_RE     = 2'b10;

  // Left wheel command for a given state
  function automatic logic [1:0] motor_esq_de(estado_t s);
    logic [1:0] m;
    m = MOTOR_PARA;
    unique case (s)
      FRENTE:   m = MOTOR_FRENTE;
      RE:       m = MOTOR_RE;
      GIRO_ESQ: m = MOTOR_RE;
      GIRO_DIR: m = MOTOR_FRENTE;
      default:  m = MOTOR_PARA;
    endcase
    return m;
  endfunction

  // Right wheel command for a given state
  function automatic logic [1:0] motor_dir_de(estado_t s);
    logic [1:0] m;
    m = MOTOR_PARA;
    unique case (s)
      FRENTE:   m = MOTOR_FRENTE;
      RE:       m = MOTOR_RE;
      GIRO_ESQ: m = MOTOR_FRENTE;
      GIRO_DIR: m = MOTOR_RE;
      default:  m = MOTOR_PARA;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/movimentacao_fsm_temporizador.sv
// Loadable down-counter timing the reverse and turn manoeuvres.
// Holds at zero; load wins over decrement.
module temporizador_manobra #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load, or count down until zero is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/movimentacao_fsm.sv
// Registered movement controller: timed reverse/turn manoeuvres,
// frontal collision counting and stuck detection.
module movimentacao_fsm
  import movimentacao_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int T_RE     = 50,
  parameter int T_GIRO   = 100,
  parameter int T_LIVRE  = 200,
  parameter int MAX_TENT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       habilita,
  input  logic       obst_frente,
  input  logic       obst_esq,
  input  logic       obst_dir,
  output logic [1:0] motor_esq,
  output logic [1:0] motor_dir,
  output logic [2:0] estado,
  output logic       preso
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cnt_w
    $error("CNT_W out of range");
  end
  if (T_RE < 1 || longint'(T_RE) > CNT_MAX) begin : g_bad_t_re
    $error("T_RE out of range");
  end
  if (T_GIRO < 1 || longint'(T_GIRO) > CNT_MAX) begin : g_bad_t_giro
    $error("T_GIRO out of range");
  end
  if (T_LIVRE < 1 || longint'(T_LIVRE) > CNT_MAX) begin : g_bad_t_livre
    $error("T_LIVRE out of range");
  end
  if (MAX_TENT < 2 || MAX_TENT > 7) begin : g_bad_max_tent
    $error("MAX_TENT out of range");
  end

  localparam logic [CNT_W-1:0] RE_INI    = CNT_W'(T_RE - 1);
  localparam logic [CNT_W-1:0] GIRO_INI  = CNT_W'(T_GIRO - 1);
  localparam logic [CNT_W-1:0] LIVRE_FIM = CNT_W'(T_LIVRE - 1);
  localparam logic [2:0]       TENT_FIM  = 3'(MAX_TENT - 1);

  estado_t          state_q, state_d;
  estado_t          dir_q, dir_d;
  logic [2:0]       tent_q, tent_d;
  logic [CNT_W-1:0] livre_q, livre_d;
  logic [1:0]       motor_esq_q, motor_dir_q;
  logic             preso_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_zero;

  assign tmr_en = (state_q == RE) || (state_q == GIRO_ESQ) ||
                  (state_q == GIRO_DIR);

  temporizador_manobra #(
    .CNT_W(CNT_W)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .en      (tmr_en),
    .zero    (tmr_zero)
  );

  // Next state, collision count, free-run count and timer loads
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    tent_d   = tent_q;
    livre_d  = livre_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!habilita) begin
      state_d  = PARADO;
      tent_d   = '0;
      livre_d  = '0;
      tmr_load = 1'b1;
      tmr_val  = '0;
    end else begin
      unique case (state_q)
        PARADO: state_d = FRENTE;
        FRENTE: begin
          livre_d = '0;
          if (obst_frente) begin
            if (tent_q == TENT_FIM) begin
              state_d = PRESO;
            end else begin
              state_d  = RE;
              tent_d   = tent_q + 3'd1;
              tmr_load = 1'b1;
              tmr_val  = RE_INI;
              dir_d    = (obst_dir && !obst_esq) ? GIRO_ESQ : GIRO_DIR;
            end
          end else if (obst_esq) begin
            state_d  = GIRO_DIR;
            tmr_load = 1'b1;
            tmr_val  = GIRO_INI;
          end else if (obst_dir) begin
            state_d  = GIRO_ESQ;
            tmr_load = 1'b1;
            tmr_val  = GIRO_INI;
          end else if (livre_q == LIVRE_FIM) begin
            livre_d = livre_q;
            tent_d  = '0;
          end else begin
            livre_d = livre_q + CNT_W'(1);
          end
        end
        RE: begin
          if (tmr_zero) begin
            state_d  = dir_q;
            tmr_load = 1'b1;
            tmr_val  = GIRO_INI;
          end
        end
        GIRO_ESQ, GIRO_DIR: begin
          if (tmr_zero) state_d = FRENTE;
        end
        PRESO:   state_d = PRESO;
        default: state_d = PARADO;
      endcase
    end
  end

  // State registers with motor and stuck outputs registered alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PARADO;
      dir_q       <= GIRO_DIR;
      tent_q      <= '0;
      livre_q     <= '0;
      motor_esq_q <= MOTOR_PARA;
      motor_dir_q <= MOTOR_PARA;
      preso_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      tent_q      <= tent_d;
      livre_q     <= livre_d;
      motor_esq_q <= motor_esq_de(state_d);
      motor_dir_q <= motor_dir_de(state_d);
      preso_q     <= (state_d == PRESO);
    end
  end

  assign motor_esq = motor_esq_q;
  assign motor_dir = motor_dir_q;
  assign estado    = state_q;
  assign preso     = preso_q;

endmodule

// File: tb/tb_movimentacao_fsm.sv
// Bench for movimentacao_fsm: vector table, directed corner
// sequences and a randomized run against a plan-queue model.
module tb_movimentacao_fsm;

  localparam int CNT_W    = 16;
  localparam int T_RE     = 4;
  localparam int T_GIRO   = 6;
  localparam int T_LIVRE  = 8;
  localparam int MAX_TENT = 3;

  typedef struct packed {
    logic [1:0] esq;
    logic [1:0] dir;
    logic [2:0] est;
    logic       pr;
  } out_t;

  localparam out_t O_STOP  = '{esq: 2'b00, dir: 2'b00, est: 3'd0, pr: 1'b0};
  localparam out_t O_FWD   = '{esq: 2'b01, dir: 2'b01, est: 3'd1, pr: 1'b0};
  localparam out_t O_RE    = '{esq: 2'b10, dir: 2'b10, est: 3'd2, pr: 1'b0};
  localparam out_t O_GE    = '{esq: 2'b10, dir: 2'b01, est: 3'd3, pr: 1'b0};
  localparam out_t O_GD    = '{esq: 2'b01, dir: 2'b10, est: 3'd4, pr: 1'b0};
  localparam out_t O_STUCK = '{esq: 2'b00, dir: 2'b00, est: 3'd5, pr: 1'b1};

  typedef struct {
    bit   h;
    bit   f;
    bit   e;
    bit   d;
    out_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       habilita = 1'b0;
  logic       obst_frente = 1'b0;
  logic       obst_esq = 1'b0;
  logic       obst_dir = 1'b0;
  logic [1:0] motor_esq;
  logic [1:0] motor_dir;
  logic [2:0] estado;
  logic       preso;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];

  // Model: what is shown now, and the queue of upcoming outputs
  out_t m_cur;
  out_t m_plan[$];
  int   m_tent;
  int   m_streak;

  movimentacao_fsm #(
    .CNT_W   (CNT_W),
    .T_RE    (T_RE),
    .T_GIRO  (T_GIRO),
    .T_LIVRE (T_LIVRE),
    .MAX_TENT(MAX_TENT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .habilita   (habilita),
    .obst_frente(obst_frente),
    .obst_esq   (obst_esq),
    .obst_dir   (obst_dir),
    .motor_esq  (motor_esq),
    .motor_dir  (motor_dir),
    .estado     (estado),
    .preso      (preso)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_plan.delete();
    m_cur    = O_STOP;
    m_tent   = 0;
    m_streak = 0;
  endfunction

  function automatic void plan_turn(out_t t);
    for (int i = 0; i < T_GIRO; i++) m_plan.push_back(t);
    m_plan.push_back(O_FWD);
  endfunction

  function automatic void model_step(bit h, bit f, bit e, bit d);
    if (!h) begin
      model_reset();
    end else if (m_plan.size() > 0) begin
      m_cur = m_plan.pop_front();
    end else if (m_cur == O_STOP) begin
      m_cur    = O_FWD;
      m_streak = 0;
    end else if (m_cur == O_FWD) begin
      if (f) begin
        m_streak = 0;
        if (m_tent == MAX_TENT - 1) begin
          m_cur = O_STUCK;
        end else begin
          m_tent++;
          for (int i = 0; i < T_RE; i++) m_plan.push_back(O_RE);
          plan_turn((d && !e) ? O_GE : O_GD);
          m_cur = m_plan.pop_front();
        end
      end else if (e) begin
        m_streak = 0;
        plan_turn(O_GD);
        m_cur = m_plan.pop_front();
      end else if (d) begin
        m_streak = 0;
        plan_turn(O_GE);
        m_cur = m_plan.pop_front();
      end else begin
        m_streak++;
        if (m_streak >= T_LIVRE) m_tent = 0;
      end
    end
  endfunction

  function automatic void add_v(int n, bit h, bit f, bit e, bit d,
                                out_t o);
    vec_t v;
    v.h = h; v.f = f; v.e = e; v.d = d; v.exp = o;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  task automatic chk_out(input string nm, input out_t exp);
    out_t act;
    act = '{esq: motor_esq, dir: motor_dir, est: estado, pr: preso};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got esq=%b dir=%b est=%0d preso=%b, want esq=%b dir=%b est=%0d preso=%b",
               nm, act.esq, act.dir, act.est, act.pr,
               exp.esq, exp.dir, exp.est, exp.pr);
    end
  endtask

  task automatic chk_tent(input string nm, input int exp);
    checks++;
    if (int'(dut.tent_q) != exp) begin
      errors++;
      $display("FAIL %s: tent got %0d want %0d", nm, dut.tent_q, exp);
    end
  endtask

  task automatic step(input bit h, input bit f, input bit e, input bit d);
    habilita = h; obst_frente = f; obst_esq = e; obst_dir = d;
    model_step(h, f, e, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    habilita = 0; obst_frente = 0; obst_esq = 0; obst_dir = 0;
    model_reset();
    @(posedge clk);
    #1;
    chk_out("reset", O_STOP);
    chk_tent("reset_tent", 0);
    rst = 1'b0;
  endtask

  task automatic hit();
    step(1, 1, 0, 0);
    repeat (T_RE + T_GIRO) step(1, 0, 0, 0);
  endtask

  initial begin
    // Table: start, frontal hit with default turn, clearing window,
    // frontal+right hit, then left and right side obstacles
    add_v(1, 1, 0, 0, 0, O_FWD);
    add_v(1, 1, 1, 0, 0, O_RE);
    add_v(3, 1, 1, 1, 1, O_RE);
    add_v(6, 1, 1, 0, 0, O_GD);
    add_v(1, 1, 0, 0, 0, O_FWD);
    add_v(8, 1, 0, 0, 0, O_FWD);
    add_v(1, 1, 1, 0, 1, O_RE);
    add_v(3, 1, 0, 0, 0, O_RE);
    add_v(6, 1, 0, 1, 0, O_GE);
    add_v(1, 1, 0, 0, 0, O_FWD);
    add_v(1, 1, 0, 1, 0, O_GD);
    add_v(5, 1, 0, 0, 0, O_GD);
    add_v(1, 1, 0, 0, 0, O_FWD);
    add_v(1, 1, 0, 0, 1, O_GE);
    add_v(5, 1, 0, 0, 0, O_GE);
    add_v(1, 1, 0, 0, 0, O_FWD);

    #3;
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].h, tbl[i].f, tbl[i].e, tbl[i].d);
      chk_out($sformatf("vec%0d", i), tbl[i].exp);
    end
    chk_tent("side_keeps_tent", 1);

    // Asynchronous reset in the middle of FRENTE
    rst = 1'b1;
    #2;
    chk_out("async_rst", O_STOP);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three quick frontal hits end in PRESO
    step(1, 0, 0, 0);
    chk_out("s4_start", O_FWD);
    hit();
    hit();
    chk_tent("s4_tent2", 2);
    step(1, 1, 0, 0);
    chk_out("s4_preso", O_STUCK);
    for (int i = 0; i < 5; i++) begin
      step(1, 1'($urandom), 1'($urandom), 1'($urandom));
      chk_out("s4_hold", O_STUCK);
    end
    step(0, 0, 0, 0);
    chk_out("s4_release", O_STOP);

    // Clearing windows between hits keep the count low
    do_reset();
    step(1, 0, 0, 0);
    hit();
    hit();
    repeat (T_LIVRE) step(1, 0, 0, 0);
    chk_tent("s5_cleared", 0);
    hit();
    repeat (T_LIVRE) step(1, 0, 0, 0);
    hit();
    chk_tent("s5_tent1", 1);
    chk_out("s5_no_preso", O_FWD);

    // Frontal hit on the cycle the window would complete: hit wins
    do_reset();
    step(1, 0, 0, 0);
    hit();
    repeat (T_LIVRE - 1) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk_tent("s5_race", 2);
    chk_out("s5_race_re", O_RE);

    // Disable during reverse with timer at 2
    do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_out("s6_parado", O_STOP);
    chk_tent("s6_tent0", 0);
    step(1, 0, 0, 0);
    chk_out("s6_frente", O_FWD);
    chk_tent("s6_tent0b", 0);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(63) != 0,
           $urandom_range(11) == 0,
           $urandom_range(15) == 0,
           $urandom_range(15) == 0);
      chk_out("rand", m_cur);
      chk_tent("rand_tent", m_tent);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/movimentacao_fsm.md
Name: movimentacao_fsm

Overview:
Sequential movement controller for the vacuum robot. Replaces the purely combinational forward/back decode with a registered state machine. It runs timed reverse and turn manoeuvres on obstacle detection, counts consecutive frontal collisions, and raises a stuck flag after a configurable number of them. It sits between the bumper/sensor inputs and the two wheel-motor drivers.

Parameters:
CNT_W, 16, width of the manoeuvre and free-run timers
T_RE, 50, cycles spent reversing after a frontal obstacle (1..2^CNT_W-1)
T_GIRO, 100, cycles spent turning (1..2^CNT_W-1)
T_LIVRE, 200, consecutive obstacle-free FRENTE cycles that clear the collision count (1..2^CNT_W-1)
MAX_TENT, 3, frontal collisions without a clearing window before entering PRESO (2..7)

Ports:
clk  in  1  system clock; one clock domain
rst  in  1  reset, asynchronous, active-high
habilita  in  1  run enable; 0 forces PARADO
obst_frente  in  1  frontal obstacle sensor, active-high
obst_esq  in  1  left obstacle sensor, active-high
obst_dir  in  1  right obstacle sensor, active-high
motor_esq  out  2  left wheel command: 00 stop, 01 forward, 10 reverse (11 never driven)
motor_dir  out  2  right wheel command, same encoding
estado  out  3  current state code, for debug
preso  out  1  stuck flag; 1 only in PRESO

Behaviour:
- Reset (async, rst=1): state is PARADO, all counters are 0, motor_esq and motor_dir are 00, preso is 0, estado is PARADO.
- Sensors are sampled synchronously on the rising edge. There is no synchroniser inside; the sensors arrive already synchronised.
- Outputs are a Moore decode of the registered state. A sensor change before edge k takes effect on the motors in the cycle after edge k, giving 1-cycle latency.
- Motor decode per state (esq/dir):
  - PARADO 00/00
  - FRENTE 01/01
  - RE 10/10
  - GIRO_ESQ 10/01
  - GIRO_DIR 01/10
  - PRESO 00/00
- Highest priority, from any state including PRESO: habilita=0 sends the FSM to PARADO and clears the collision count, the timer and the free-run counter.
- PARADO: habilita=1 moves to FRENTE.
- FRENTE, evaluated in priority order:
  - obst_frente=1 with tent==MAX_TENT-1: go to PRESO.
  - obst_frente=1 otherwise: go to RE, increment tent, load timer with T_RE-1, and latch the turn direction. The direction is GIRO_ESQ if obst_dir=1 and obst_esq=0; otherwise it is GIRO_DIR.
  - obst_esq=1: go to GIRO_DIR, load timer with T_GIRO-1.
  - obst_dir=1: go to GIRO_ESQ, load timer with T_GIRO-1.
  - Side obstacles do not change tent.
- RE:
  - The timer decrements each cycle.
  - At timer==0, go to the latched GIRO state and load T_GIRO-1.
  - RE therefore lasts exactly T_RE cycles.
  - Sensors are ignored in RE.
- GIRO_ESQ / GIRO_DIR:
  - The timer decrements each cycle.
  - At timer==0, return to FRENTE. GIRO therefore lasts exactly T_GIRO cycles.
  - Sensors are ignored during the turn.
- Free-run counter (livre):
  - Counts cycles in FRENTE with all three sensors 0.
  - Resets to 0 on any sensor=1 and on leaving FRENTE.
  - When it reaches T_LIVRE-1, tent clears to 0 and livre saturates until it is reset.
- PRESO: preso=1 and motors stop. The only exit is habilita=0, which goes to PARADO.
- tent is 3 bits and never exceeds MAX_TENT-1.
- Timer width is CNT_W. Parameter values beyond the ranges above are illegal; the RTL raises an elaboration-time error for them.
- Simultaneous events:
  - habilita=0 beats every sensor.
  - In FRENTE, a frontal obstacle beats side obstacles.
  - A frontal obstacle on the same cycle livre would saturate: the obstacle wins, livre does not clear tent, and tent increments.
- rst asserted mid-manoeuvre aborts immediately to the reset values, asynchronously.

Decomposition:
- movimentacao_pkg holds:
  - the state encoding PARADO=0, FRENTE=1, RE=2, GIRO_ESQ=3, GIRO_DIR=4, PRESO=5
  - motor code constants MOTOR_PARA=00, MOTOR_FRENTE=01, MOTOR_RE=10
- One sub-module, temporizador_manobra: a CNT_W-bit loadable down-counter with inputs load, load_val, en and output zero, reset to 0.
- The FSM, tent and livre logic stay in movimentacao_fsm.

Test Plan:
All scenarios use T_RE=4, T_GIRO=6, T_LIVRE=8, MAX_TENT=3.
1. Reset then habilita=1: first cycle motors 00/00 (PARADO), next cycle 01/01. Pulse rst mid-FRENTE -> motors 00/00 within the same cycle, preso=0.
2. In FRENTE, obst_frente=1 with obst_esq=obst_dir=0 for one cycle -> exactly 4 cycles of 10/10, then 6 cycles of 01/10 (GIRO_DIR), then 01/01.
3. In FRENTE, obst_frente=1 and obst_dir=1 -> 4 cycles of 10/10, then 6 cycles of 10/01 (GIRO_ESQ). Separately, obst_esq alone -> 6 cycles of 01/10, no RE, tent unchanged.
4. Three frontal hits, each re-triggered within 8 free cycles -> after the third hit, motors 00/00 and preso=1, holding with habilita=1. Drop habilita -> PARADO next cycle, preso=0.
5. Two frontal hits, then 8 obstacle-free FRENTE cycles, then two more hits -> no PRESO; tent reads 1 after the final hit.
6. habilita=0 during RE at timer=2 -> PARADO next cycle. Re-enable -> FRENTE with tent=0.
